// File: rtl/tape_pkg.sv
// rtl/tape_pkg.sv - shared cassette tape FSM states and default timing constants
package tape_pkg;

    localparam int TAPE_MIN_HALF  = 4;
    localparam int TAPE_SHORT_MAX = 24;
    localparam int TAPE_LONG_MAX  = 64;
    localparam int TAPE_SILENCE   = 4096;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HUNT,
        ST_DATA,
        ST_STOP,
        ST_WRITE,
        ST_DONE
    } tape_state_e;

    typedef enum logic [1:0] {
        HP_SHORT,
        HP_LONG,
        HP_GAP
    } half_cls_e;

endpackage

// File: rtl/tape_pulse_cls.sv
// rtl/tape_pulse_cls.sv - cassette input synchroniser, half-period counter and classifier
module tape_pulse_cls
    import tape_pkg::*;
#(
    parameter int MIN_HALF  = TAPE_MIN_HALF,
    parameter int SHORT_MAX = TAPE_SHORT_MAX,
    parameter int LONG_MAX  = TAPE_LONG_MAX
) (
    input  logic      clk_i,
    input  logic      rst_i,
    input  logic      ce_i,
    input  logic      cass_i,
    output logic      edge_o,
    output logic      pulse_o,
    output half_cls_e cls_o
);

    localparam int            CW      = $clog2(LONG_MAX + 3);
    localparam logic [CW-1:0] CNT_SAT = CW'(LONG_MAX + 1);

    logic          sync1_q, sync2_q, last_q;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] meas;

    // meas is the length of the half-period that an edge on this tick would close
    assign meas    = cnt_q + 1'b1;
    assign edge_o  = ce_i && (sync2_q != last_q);
    assign pulse_o = edge_o && (meas >= CW'(MIN_HALF));

    always_comb begin
        cls_o = HP_GAP;
        if (meas <= CW'(SHORT_MAX)) begin
            cls_o = HP_SHORT;
        end else if (meas <= CW'(LONG_MAX)) begin
            cls_o = HP_LONG;
        end
    end

    // Glitch edges update the reference level but leave the counter running
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            last_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= cass_i;
            sync2_q <= sync1_q;
            if (ce_i) begin
                last_q <= sync2_q;
                if (pulse_o) begin
                    cnt_q <= '0;
                end else if (cnt_q != CNT_SAT) begin
                    cnt_q <= meas;
                end
            end
        end
    end

endmodule

// File: rtl/tape_rec.sv
// rtl/tape_rec.sv - cassette recorder: pairs half-periods into bits, frames bytes, writes tape RAM
module tape_rec
    import tape_pkg::*;
#(
    parameter int MIN_HALF  = TAPE_MIN_HALF,
    parameter int SHORT_MAX = TAPE_SHORT_MAX,
    parameter int LONG_MAX  = TAPE_LONG_MAX,
    parameter int SILENCE   = TAPE_SILENCE
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ce_tape,
    input  logic        arm,
    input  logic        cass,
    output logic [15:0] addr,
    output logic [7:0]  data,
    output logic        we,
    output logic [15:0] length,
    output logic        busy,
    output logic        done,
    output logic        overflow,
    output logic        frame_err
);

    localparam int            SW       = $clog2(SILENCE + 1);
    localparam logic [SW-1:0] SIL_LAST = SW'(SILENCE - 1);

    tape_state_e   state_q;
    half_cls_e     cls_w, pend_cls_q;
    logic          edge_w, pulse_w;
    logic          arm_q, pend_v_q, stop_cnt_q;
    logic [7:0]    shift_q, data_q;
    logic [2:0]    bit_cnt_q;
    logic [SW-1:0] sil_q;
    logic [15:0]   length_q;
    logic          we_q, busy_q, done_q, ovf_q, ferr_q;
    logic          active, bit_v, bit_val, sil_exp, go_done;

    tape_pulse_cls #(
        .MIN_HALF (MIN_HALF),
        .SHORT_MAX(SHORT_MAX),
        .LONG_MAX (LONG_MAX)
    ) u_cls (
        .clk_i  (clk),
        .rst_i  (reset),
        .ce_i   (ce_tape),
        .cass_i (cass),
        .edge_o (edge_w),
        .pulse_o(pulse_w),
        .cls_o  (cls_w)
    );

    assign active  = (state_q == ST_HUNT) || (state_q == ST_DATA) || (state_q == ST_STOP);
    assign bit_v   = pulse_w && (cls_w != HP_GAP) && pend_v_q && (pend_cls_q == cls_w);
    assign bit_val = (cls_w == HP_SHORT);
    assign sil_exp = ce_tape && !edge_w && (sil_q == SIL_LAST);

    always_comb begin
        go_done = 1'b0;
        if (active) begin
            go_done = !arm || (sil_exp && (length_q != '0));
        end else if (state_q == ST_WRITE) begin
            go_done = !arm || (length_q == 16'hFFFF);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            arm_q      <= 1'b0;
            pend_v_q   <= 1'b0;
            pend_cls_q <= HP_SHORT;
            shift_q    <= '0;
            bit_cnt_q  <= '0;
            stop_cnt_q <= 1'b0;
            sil_q      <= '0;
            length_q   <= '0;
            data_q     <= '0;
            we_q       <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            ovf_q      <= 1'b0;
            ferr_q     <= 1'b0;
        end else begin
            arm_q  <= arm;
            we_q   <= 1'b0;
            ferr_q <= 1'b0;

            if (!(active || state_q == ST_WRITE)) begin
                sil_q <= '0;
            end else if (ce_tape) begin
                sil_q <= (edge_w || sil_q == SIL_LAST) ? '0 : sil_q + 1'b1;
            end

            // A mixed pair keeps the newer half as the first half of the next bit
            if (pulse_w) begin
                if (cls_w == HP_GAP || bit_v) begin
                    pend_v_q <= 1'b0;
                end else begin
                    pend_v_q   <= 1'b1;
                    pend_cls_q <= cls_w;
                end
            end

            if (state_q == ST_WRITE) begin
                if (length_q == 16'hFFFF) begin
                    ovf_q <= 1'b1;
                end else begin
                    length_q <= length_q + 16'd1;
                end
            end

            if (go_done) begin
                state_q <= ST_DONE;
                busy_q  <= 1'b0;
                done_q  <= 1'b1;
            end else begin
                case (state_q)
                    ST_IDLE, ST_DONE: begin
                        if (arm && !arm_q) begin
                            state_q  <= ST_HUNT;
                            length_q <= '0;
                            busy_q   <= 1'b1;
                            done_q   <= 1'b0;
                            ovf_q    <= 1'b0;
                            pend_v_q <= 1'b0;
                        end
                    end
                    ST_WRITE: state_q <= ST_HUNT;
                    default: begin
                        if (pulse_w && cls_w == HP_GAP) begin
                            state_q <= ST_HUNT;
                        end else if (bit_v) begin
                            if (state_q == ST_HUNT) begin
                                if (!bit_val) begin
                                    state_q   <= ST_DATA;
                                    bit_cnt_q <= '0;
                                end
                            end else if (state_q == ST_DATA) begin
                                shift_q   <= {shift_q[6:0], bit_val};
                                bit_cnt_q <= bit_cnt_q + 3'd1;
                                if (bit_cnt_q == 3'd7) begin
                                    state_q    <= ST_STOP;
                                    stop_cnt_q <= 1'b0;
                                end
                            end else if (!bit_val) begin
                                ferr_q  <= 1'b1;
                                state_q <= ST_HUNT;
                            end else if (stop_cnt_q) begin
                                state_q <= ST_WRITE;
                                we_q    <= 1'b1;
                                data_q  <= shift_q;
                            end else begin
                                stop_cnt_q <= 1'b1;
                            end
                        end else if (sil_exp) begin
                            state_q  <= ST_HUNT;
                            pend_v_q <= 1'b0;
                        end
                    end
                endcase
            end
        end
    end

    // addr tracks length: every byte lands at the current count
    assign addr      = length_q;
    assign data      = data_q;
    assign we        = we_q;
    assign length    = length_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign overflow  = ovf_q;
    assign frame_err = ferr_q;

endmodule

// File: tb/tb_tape_rec.sv
// tb/tb_tape_rec.sv - directed self-checking bench for tape_rec
module tb_tape_rec;

    logic        clk = 1'b0;
    logic        reset;
    logic        ce_tape = 1'b0;
    logic        arm = 1'b0;
    logic        cass = 1'b0;
    logic [15:0] addr;
    logic [7:0]  data;
    logic        we;
    logic [15:0] length;
    logic        busy;
    logic        done;
    logic        overflow;
    logic        frame_err;

    int          n_cmp = 0;
    int          n_err = 0;
    int          wr_cnt = 0;
    int          fe_cnt = 0;
    logic [7:0]  ram [0:15];

    tape_rec dut (
        .clk      (clk),
        .reset    (reset),
        .ce_tape  (ce_tape),
        .arm      (arm),
        .cass     (cass),
        .addr     (addr),
        .data     (data),
        .we       (we),
        .length   (length),
        .busy     (busy),
        .done     (done),
        .overflow (overflow),
        .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (we) begin
            ram[addr[3:0]] <= data;
            wr_cnt         <= wr_cnt + 1;
        end
        if (frame_err) begin
            fe_cnt <= fe_cnt + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(negedge clk) ce_tape = 1'b1;
            @(negedge clk) ce_tape = 1'b0;
        end
    endtask

    task automatic halfp(input int h);
        tick(h);
        cass = ~cass;
    endtask

    task automatic send_bit(input logic b);
        halfp(b ? 12 : 40);
        halfp(b ? 12 : 40);
    endtask

    task automatic send_frame(input logic [7:0] v, input logic s1, input logic s2);
        send_bit(1'b0);
        for (int i = 7; i >= 0; i--) begin
            send_bit(v[i]);
        end
        send_bit(s1);
        send_bit(s2);
    endtask

    task automatic arm_low();
        @(negedge clk) arm = 1'b0;
        @(negedge clk);
    endtask

    task automatic arm_high();
        @(negedge clk) arm = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        reset = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_addr", 32'(addr), 32'h0);
        check("rst_data", 32'(data), 32'h0);
        check("rst_we", 32'(we), 32'h0);
        check("rst_length", 32'(length), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_done", 32'(done), 32'h0);
        check("rst_ovf", 32'(overflow), 32'h0);
        check("rst_ferr", 32'(frame_err), 32'h0);
        reset = 1'b0;
        @(negedge clk);

        // single byte 0xA5
        arm_high();
        check("arm_busy", 32'(busy), 32'h1);
        halfp(100);
        send_frame(8'hA5, 1'b1, 1'b1);
        tick(2);
        check("a5_we", 32'(we), 32'h1);
        check("a5_addr", 32'(addr), 32'h0);
        check("a5_data", 32'(data), 32'hA5);
        tick(1);
        check("a5_we_drop", 32'(we), 32'h0);
        check("a5_length", 32'(length), 32'h1);

        // disarm freezes, re-arm clears
        arm_low();
        check("disarm_done", 32'(done), 32'h1);
        check("disarm_busy", 32'(busy), 32'h0);
        check("disarm_length", 32'(length), 32'h1);
        arm_high();
        check("rearm_done", 32'(done), 32'h0);
        check("rearm_length", 32'(length), 32'h0);
        check("rearm_busy", 32'(busy), 32'h1);

        // three bytes then silence boundary
        halfp(100);
        send_frame(8'h00, 1'b1, 1'b1);
        send_frame(8'hFF, 1'b1, 1'b1);
        send_frame(8'h3C, 1'b1, 1'b1);
        tick(4097);
        check("sil_early_done", 32'(done), 32'h0);
        check("sil_early_busy", 32'(busy), 32'h1);
        tick(1);
        check("sil_done", 32'(done), 32'h1);
        check("sil_busy", 32'(busy), 32'h0);
        check("sil_length", 32'(length), 32'h3);
        check("ram0", 32'(ram[0]), 32'h00);
        check("ram1", 32'(ram[1]), 32'hFF);
        check("ram2", 32'(ram[2]), 32'h3C);
        check("wr_cnt_4", 32'(wr_cnt), 32'd4);

        // bad first stop bit
        arm_low();
        arm_high();
        halfp(100);
        send_frame(8'h55, 1'b0, 1'b1);
        tick(4);
        check("ferr_cnt", 32'(fe_cnt), 32'd1);
        check("ferr_no_we", 32'(wr_cnt), 32'd4);
        check("ferr_length", 32'(length), 32'h0);
        send_frame(8'h11, 1'b1, 1'b1);
        tick(2);
        check("x11_we", 32'(we), 32'h1);
        check("x11_addr", 32'(addr), 32'h0);
        check("x11_data", 32'(data), 32'h11);

        // glitches and a mixed pair ahead of the start bit
        arm_low();
        arm_high();
        halfp(100);
        halfp(2);
        halfp(100);
        halfp(3);
        halfp(100);
        halfp(12);
        halfp(40);
        halfp(12);
        halfp(12);
        send_frame(8'h77, 1'b1, 1'b1);
        tick(2);
        check("x77_we", 32'(we), 32'h1);
        check("x77_addr", 32'(addr), 32'h0);
        check("x77_data", 32'(data), 32'h77);
        check("x77_ferr", 32'(fe_cnt), 32'd1);
        tick(1);
        check("x77_length", 32'(length), 32'h1);

        // write at the last address
        arm_low();
        arm_high();
        force dut.length_q = 16'hFFFF;
        halfp(100);
        send_frame(8'h42, 1'b1, 1'b1);
        tick(2);
        check("ovf_we", 32'(we), 32'h1);
        check("ovf_addr", 32'(addr), 32'hFFFF);
        check("ovf_data", 32'(data), 32'h42);
        tick(1);
        check("ovf_flag", 32'(overflow), 32'h1);
        check("ovf_done", 32'(done), 32'h1);
        check("ovf_busy", 32'(busy), 32'h0);
        send_frame(8'h24, 1'b1, 1'b1);
        tick(4);
        check("ovf_no_more_we", 32'(wr_cnt), 32'd7);
        check("ovf_sticky", 32'(overflow), 32'h1);
        release dut.length_q;
        arm_low();
        arm_high();
        check("rearm_ovf", 32'(overflow), 32'h0);
        check("rearm_len0", 32'(length), 32'h0);

        // reset during a write
        halfp(100);
        send_frame(8'h99, 1'b1, 1'b1);
        tick(2);
        check("mid_we", 32'(we), 32'h1);
        reset = 1'b1;
        #1;
        check("mid_rst_we", 32'(we), 32'h0);
        check("mid_rst_addr", 32'(addr), 32'h0);
        check("mid_rst_data", 32'(data), 32'h0);
        check("mid_rst_length", 32'(length), 32'h0);
        check("mid_rst_busy", 32'(busy), 32'h0);
        check("mid_rst_done", 32'(done), 32'h0);
        check("mid_rst_ovf", 32'(overflow), 32'h0);
        arm = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        arm_high();
        halfp(100);
        send_frame(8'h5A, 1'b1, 1'b1);
        tick(2);
        check("post_we", 32'(we), 32'h1);
        check("post_addr", 32'(addr), 32'h0);
        check("post_data", 32'(data), 32'h5A);
        tick(1);
        check("post_length", 32'(length), 32'h1);
        check("post_busy", 32'(busy), 32'h1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/tape_rec.md
TAPE_REC -- requirements
Module: tape_rec

Interface
REQ-001 Parameter MIN_HALF, default 4: half-periods of MIN_HALF-1 ticks or fewer are glitches and are ignored.
REQ-002 Parameter SHORT_MAX, default 24: a half-period of MIN_HALF..SHORT_MAX ticks is SHORT.
REQ-003 Parameter LONG_MAX, default 64: a half-period of SHORT_MAX+1..LONG_MAX ticks is LONG; anything longer is GAP.
REQ-004 Parameter SILENCE, default 4096: number of edge-free ticks that ends a recording.
REQ-005 clk  in  1  system clock; the only clock.
REQ-006 reset  in  1  asynchronous, active-high.
REQ-007 ce_tape  in  1  one-clk sampling tick; all timing counts in ticks.
REQ-008 arm  in  1  level; 1 = recording enabled.
REQ-009 cass  in  1  raw cassette output bit from the PLA.
REQ-010 addr  out  16  buffer write address.
REQ-011 data  out  8  buffer write data.
REQ-012 we  out  1  one-clk write strobe to tape RAM port.
REQ-013 length  out  16  bytes stored so far.
REQ-014 busy  out  1  recording in progress.
REQ-015 done  out  1  recording finished; held until re-arm or reset.
REQ-016 overflow  out  1  buffer full; sticky until re-arm or reset.
REQ-017 frame_err  out  1  one-clk pulse on a bad stop bit.

Function
REQ-018 cass shall pass a 2-flop synchroniser; an edge is any change of the synchronised value, and it is evaluated only on ce_tape.
REQ-019 A saturating half-period counter shall increment on each ce_tape, and shall be classified and cleared on each accepted edge.
REQ-020 One bit = two consecutive half-periods of the same class: SHORT+SHORT = 1, LONG+LONG = 0.
REQ-021 A mixed pair shall discard the first half and keep the second as the new first half (resync); a GAP shall clear the pair and return the FSM to HUNT.
REQ-022 FSM states: IDLE, HUNT, DATA, STOP, WRITE, DONE.
REQ-023 IDLE -> HUNT when arm rises: clear length, addr, done, overflow; set busy.
REQ-024 In HUNT, a 0 bit (start bit) -> DATA with bit count cleared; 1 bits are ignored.
REQ-025 DATA shall shift in 8 bits MSB first; after the 8th bit -> STOP.
REQ-026 STOP shall expect two 1 bits. Both 1 -> WRITE. A 0 -> pulse frame_err, discard the byte, go to HUNT.
REQ-027 WRITE shall drive data, assert we for exactly one clk at addr = length, then increment length and addr, then go to HUNT.
REQ-028 When a write lands at addr 0xFFFF, set overflow and go to DONE; no further writes.
REQ-029 SILENCE consecutive edge-free ticks in HUNT/DATA/STOP with length != 0 -> DONE; with length == 0, stay in HUNT.
REQ-030 arm falling in any state other than IDLE/DONE -> DONE immediately; a partial byte is discarded.
REQ-031 In DONE: busy=0, done=1, length frozen. arm low then high -> IDLE sequence of REQ-023.
REQ-032 If an edge and a silence expiry occur on the same tick, the edge wins.
REQ-033 we shall never be asserted outside WRITE.
REQ-034 Latency: we shall assert within 2 clks of the ce_tape that completes the second stop bit.

Reset
REQ-035 reset shall force IDLE; addr=0, data=0, we=0, length=0, busy=0, done=0, overflow=0, frame_err=0; clear counters and synchroniser flops (to 0).
REQ-036 reset asserted mid-write shall drop we in the same cycle; no partial state shall survive.

Structure
REQ-037 The FSM state enum and the default timing constants shall live in a shared tape package, also used by the playback block.
REQ-038 One sub-module, tape_pulse_cls, shall hold the synchroniser, half-period counter and SHORT/LONG/GAP classifier; pairing and framing stay in tape_rec.

Verification
REQ-039 Arm; send start 0, byte 0xA5, stop 1 1 (SHORT=12 ticks, LONG=40 ticks) -> one we with addr=0, data=0xA5; length=1.
REQ-040 Send 3 bytes 0x00, 0xFF, 0x3C, then 4096 idle ticks -> done=1, busy=0, length=3, RAM[0..2] correct.
REQ-041 Byte 0x55 with first stop bit 0 -> frame_err pulse, no we; next valid 0x11 -> written at addr 0.
REQ-042 Inject 2-tick glitches and one mixed SHORT/LONG pair before the start bit -> 0x77 still decoded correctly.
REQ-043 Preload length to 0xFFFF via 65535 bytes (or forced state) plus one byte -> overflow=1, done=1, no further we.
REQ-044 Assert reset during WRITE -> we=0 the same cycle; all outputs at reset values; re-arm records normally.
